uart_tx: RTL and testbench

UART transmitter that serializes one byte per request into a standard asynchronous frame: one start bit, 8 data bits LSB first, an optional even-parity bit, and stop bit(s). It is the transmit half of the UART link. It shares the `b_tick` oversampling tick from the baud generator with the receiver, and its frame format is bit-compatible with that receiver. The block sits between the watch or sensor data formatter, which issues bytes, and the board TX pin.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_tx_if.sv | 12 +
 rtl/uart_tx.sv | 171 +++++++++++++++++
 tb/tb_uart_tx.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: TX state encoding, default oversampling rate and
// frame bit counts so the transmitter and receiver agree on the frame format.
package uart_pkg;

    localparam int TICKS_PER_BIT_DEF = 8;
    localparam int START_BITS        = 1;
    localparam int DATA_BITS         = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    // Even parity: the bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte request handshake between the data formatter (master) and uart_tx (slave).
interface uart_tx_if;

    logic       i_start;
    logic [7:0] i_din;
    logic       o_tx_busy;
    logic       o_tx_done;

    modport master (output i_start, output i_din, input o_tx_busy, input o_tx_done);
    modport slave  (input i_start, input i_din, output o_tx_busy, output o_tx_done);

endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional even parity, stop bit(s).
// Optional parity bit is compiled in with the UART_TX_PARITY_EN macro.
module uart_tx
    import uart_pkg::*;
#(
    parameter int TICKS_PER_BIT = TICKS_PER_BIT_DEF,
    parameter int STOP_BITS     = 1
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      b_tick,
    uart_tx_if.slave  bus,
    output logic      o_tx
);

    localparam int TW = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;

    tx_state_t       r_state;
    logic [TW-1:0]   r_tick;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic            r_tx;
    logic            r_busy;
    logic            r_done;

    tx_state_t       w_state;
    logic [TW-1:0]   w_tick;
    logic [2:0]      w_bit;
    logic [7:0]      w_shift;
    logic            w_tx;
    logic            w_busy;
    logic            w_done;
    logic            w_tick_end;

`ifdef UART_TX_PARITY_EN
    logic            r_par;
    logic            w_par;
`endif

    assign w_tick_end    = b_tick && (r_tick == TW'(TICKS_PER_BIT - 1));
    assign o_tx          = r_tx;
    assign bus.o_tx_busy = r_busy;
    assign bus.o_tx_done = r_done;

    // Next-state, counters and shift register.
    always_comb begin
        w_state = r_state;
        w_bit   = r_bit;
        w_shift = r_shift;
        w_done  = 1'b0;
`ifdef UART_TX_PARITY_EN
        w_par   = r_par;
`endif
        if (w_tick_end) begin
            w_tick = '0;
        end else if (b_tick) begin
            w_tick = r_tick + TW'(1);
        end else begin
            w_tick = r_tick;
        end

        case (r_state)
            ST_IDLE: begin
                // A tick on the acceptance cycle must not count toward the start bit.
                w_tick = '0;
                if (bus.i_start) begin
                    w_shift = bus.i_din;
                    w_bit   = 3'd0;
                    w_state = ST_START;
`ifdef UART_TX_PARITY_EN
                    w_par   = even_parity(bus.i_din);
`endif
                end else begin
                    w_state = ST_IDLE;
                end
            end
            ST_START: begin
                if (w_tick_end) begin
                    w_state = ST_DATA;
                end else begin
                    w_state = ST_START;
                end
            end
            ST_DATA: begin
                if (w_tick_end) begin
                    w_shift = {1'b0, r_shift[7:1]};
                    if (r_bit == 3'(DATA_BITS - 1)) begin
                        w_bit   = 3'd0;
`ifdef UART_TX_PARITY_EN
                        w_state = ST_PARITY;
`else
                        w_state = ST_STOP;
`endif
                    end else begin
                        w_bit   = r_bit + 3'd1;
                    end
                end else begin
                    w_state = ST_DATA;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (w_tick_end) begin
                    w_state = ST_STOP;
                end else begin
                    w_state = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                if (w_tick_end) begin
                    if (r_bit == 3'(STOP_BITS - 1)) begin
                        w_bit   = 3'd0;
                        w_state = ST_IDLE;
                        w_done  = 1'b1;
                    end else begin
                        w_bit   = r_bit + 3'd1;
                    end
                end else begin
                    w_state = ST_STOP;
                end
            end
            default: begin
                w_state = ST_IDLE;
                w_tick  = '0;
                w_bit   = 3'd0;
            end
        endcase
    end

    // Line level and busy derived from the next state so outputs can be registered.
    always_comb begin
        w_busy = (w_state != ST_IDLE);
        case (w_state)
            ST_START:  w_tx = 1'b0;
            ST_DATA:   w_tx = w_shift[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: w_tx = w_par;
`endif
            default:   w_tx = 1'b1;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_tick  <= '0;
            r_bit   <= 3'd0;
            r_shift <= 8'h00;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_state;
            r_tick  <= w_tick;
            r_bit   <= w_bit;
            r_shift <= w_shift;
            r_tx    <= w_tx;
            r_busy  <= w_busy;
            r_done  <= w_done;
`ifdef UART_TX_PARITY_EN
            r_par   <= w_par;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: expected line levels come from a frame-bit
// table indexed by the number of b_tick pulses seen since acceptance.
module tb_uart_tx;

    localparam int TPB = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int LIM = NB * TPB * 4 + 100;

    logic clk;
    logic rst;
    logic b_tick;
    logic o_tx;
    int   n_checks = 0;
    int   n_fails  = 0;
    int   tcnt     = 0;

    uart_tx_if u_if ();

    uart_tx #(.TICKS_PER_BIT(TPB), .STOP_BITS(1)) dut (
        .clk    (clk),
        .rst    (rst),
        .b_tick (b_tick),
        .bus    (u_if),
        .o_tx   (o_tx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One b_tick every 4 clk, changed on the falling edge.
    initial begin
        b_tick = 1'b0;
        forever begin
            @(negedge clk);
            b_tick = (tcnt == 3);
            tcnt   = (tcnt + 1) % 4;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference frame: bit k of the result is the line level during bit period k.
    function automatic logic [11:0] frame_bits(input logic [7:0] d);
        logic [11:0] f;
        int ones;
        f    = '1;
        f[0] = 1'b0;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            f[i+1] = d[i];
            ones   = ones + int'(d[i]);
        end
`ifdef UART_TX_PARITY_EN
        f[9] = ((ones % 2) == 1);
`endif
        return f;
    endfunction

    task automatic accept(input logic [7:0] d, input bit hold);
        u_if.i_start = 1'b1;
        u_if.i_din   = d;
        @(posedge clk);
        #1;
        if (!hold) u_if.i_start = 1'b0;
    endtask

    task automatic idle_check(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            chk("idle_tx", o_tx, 1'b1);
            chk("idle_busy", u_if.o_tx_busy, 1'b0);
            chk("idle_done", u_if.o_tx_done, 1'b0);
        end
    endtask

    // Follows one frame from the cycle after acceptance to the done pulse.
    task automatic check_frame(input logic [7:0] d, input int inj, input int rst_at);
        logic [11:0] fb;
        logic [7:0]  rx;
        int n;
        int c;
        bit fin;
        fb  = frame_bits(d);
        rx  = 8'h00;
        n   = 0;
        c   = 0;
        fin = 1'b0;
        while (!fin && c <= LIM) begin
            @(negedge clk);
            if (n >= NB * TPB) begin
                chk("done_pulse", u_if.o_tx_done, 1'b1);
                chk("done_busy", u_if.o_tx_busy, 1'b0);
                chk("done_tx", o_tx, 1'b1);
                chk("loopback", rx, d);
                fin = 1'b1;
            end else begin
                chk("frame_tx", o_tx, fb[n / TPB]);
                chk("frame_busy", u_if.o_tx_busy, 1'b1);
                chk("frame_done", u_if.o_tx_done, 1'b0);
                if ((n % TPB) == TPB / 2 && n >= TPB && n < 9 * TPB) rx[n / TPB - 1] = o_tx;
            end
            if (inj >= 0 && c == inj) begin
                u_if.i_start = 1'b1;
                u_if.i_din   = 8'hFF;
            end
            if (inj >= 0 && c == inj + 1) u_if.i_start = 1'b0;
            if (!fin && rst_at >= 0 && n == rst_at) begin
                rst = 1'b0;
                #1;
                chk("rst_tx", o_tx, 1'b1);
                chk("rst_busy", u_if.o_tx_busy, 1'b0);
                chk("rst_done", u_if.o_tx_done, 1'b0);
                repeat (4) begin
                    @(negedge clk);
                    chk("rst_hold_tx", o_tx, 1'b1);
                    chk("rst_hold_done", u_if.o_tx_done, 1'b0);
                end
                rst = 1'b1;
                fin = 1'b1;
            end
            c++;
            if (!fin) begin
                @(posedge clk);
                if (b_tick) n++;
            end
        end
        if (!fin) chk("frame_timeout", fin, 1'b1);
    endtask

    initial begin
        logic [7:0] rnd;
        rst          = 1'b0;
        u_if.i_start = 1'b0;
        u_if.i_din   = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_tx", o_tx, 1'b1);
        chk("reset_busy", u_if.o_tx_busy, 1'b0);
        chk("reset_done", u_if.o_tx_done, 1'b0);
        rst = 1'b1;
        idle_check(40);

        @(negedge clk); accept(8'h55, 1'b0); check_frame(8'h55, -1, -1);
        idle_check(5);
        @(negedge clk); accept(8'hA3, 1'b0); check_frame(8'hA3, -1, -1);
        idle_check(5);

        // Request while busy must be ignored, and nothing follows the frame.
        @(negedge clk); accept(8'h0F, 1'b0); check_frame(8'h0F, 100, -1);
        idle_check(40);

        // Back-to-back frames with i_start held high.
        @(negedge clk); accept(8'h3C, 1'b1); check_frame(8'h3C, -1, -1);
        accept(8'hC3, 1'b0); check_frame(8'hC3, -1, -1);
        idle_check(5);

        // Reset during D3.
        @(negedge clk); accept(8'h81, 1'b0); check_frame(8'h81, -1, 4 * TPB + 4);
        idle_check(10);

        @(negedge clk); accept(8'h00, 1'b0); check_frame(8'h00, -1, -1);
        @(negedge clk); accept(8'hFF, 1'b0); check_frame(8'hFF, -1, -1);
        @(negedge clk); accept(8'h81, 1'b0); check_frame(8'h81, -1, -1);
        for (int k = 0; k < 4; k++) begin
            rnd = 8'($urandom_range(0, 255));
            repeat ($urandom_range(0, 7)) @(negedge clk);
            @(negedge clk); accept(rnd, 1'b0); check_frame(rnd, -1, -1);
        end
        idle_check(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
